// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: round-robin scan of a multiplexed common-anode 7-segment bank
// with brightness PWM, ghost blanking and leading-zero blanking.
module seg_scan_ctrl #(
    parameter int NDIG     = 8,
    parameter int PRESCALE = 10000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       WR_EN,
    input  logic [2:0] WR_ADDR,
    input  logic [3:0] WR_DATA,
    input  logic [7:0] EN_MASK,
    input  logic [3:0] BRIGHT,
    input  logic       LZB,
    output logic [6:0] SEG_C,
    output logic [7:0] SEG_SEL,
    output logic       FRAME_DONE
);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [7:0] VALID = 8'((1 << NDIG) - 1);
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Unused upper entries stay zero so the leading-zero scan can cover all 8.
    logic [3:0]    dig [8];
    logic [2:0]    ptr, ptr_nxt, lo_idx, hi_idx;
    logic [PW-1:0] pre;
    logic [3:0]    pwm;
    logic [7:0]    mask;
    logic          tick, wrap, dark, lead_zero, hi_found;

    always_comb begin
        mask      = EN_MASK & VALID;
        tick      = pre == PW'(PRESCALE - 1);
        lo_idx    = ptr;
        hi_idx    = ptr;
        hi_found  = 1'b0;
        lead_zero = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                lo_idx = 3'(i);
                if (3'(i) > ptr) begin
                    hi_idx   = 3'(i);
                    hi_found = 1'b1;
                end
            end
            if (3'(i) >= ptr && dig[i] != 4'h0) lead_zero = 1'b0;
        end
        // With nothing enabled lo_idx keeps its default, so the pointer holds.
        ptr_nxt = hi_found ? hi_idx : lo_idx;
        wrap    = tick && (|mask) && ptr_nxt <= ptr;
        dark    = pre == '0 || !mask[ptr] || pwm > BRIGHT || (LZB && ptr != 3'd0 && lead_zero);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < 8; k++) dig[k] <= 4'h0;
            ptr        <= '0;
            pre        <= '0;
            pwm        <= '0;
            SEG_SEL    <= 8'hFF;
            SEG_C      <= 7'h00;
            FRAME_DONE <= 1'b0;
        end else begin
            if (WR_EN && int'(WR_ADDR) < NDIG) dig[WR_ADDR] <= WR_DATA;
            pre        <= tick ? '0 : pre + 1'b1;
            if (tick) ptr <= ptr_nxt;
            pwm        <= pwm + 1'b1;
            SEG_SEL    <= dark ? 8'hFF : ~(8'h01 << ptr);
            SEG_C      <= dark ? 7'h00 : SEG_LUT[dig[ptr]];
            FRAME_DONE <= wrap;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed scan scenarios on two configurations, checked
// cycle by cycle against a queued reference model.
module tb_seg_scan_ctrl;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       WR_EN = 1'b0;
    logic [2:0] WR_ADDR = '0;
    logic [3:0] WR_DATA = '0;
    logic [7:0] EN_MASK = 8'hFF;
    logic [3:0] BRIGHT = 4'hF;
    logic       LZB = 1'b0;
    logic [6:0] seg0, seg1;
    logic [7:0] sel0, sel1;
    logic       fd0, fd1;

    int checks = 0;
    int failures = 0;
    string phase = "reset";

    int nd [2] = '{8, 6};
    int ps [2] = '{4, 32};
    logic [3:0] m_dig [2][8];
    int m_ptr [2];
    int m_pre [2];
    logic [3:0] m_pwm;
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_scan_ctrl #(.NDIG(8), .PRESCALE(4)) u0 (
        .CLK(CLK), .RESET(RESET), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .EN_MASK(EN_MASK), .BRIGHT(BRIGHT), .LZB(LZB),
        .SEG_C(seg0), .SEG_SEL(sel0), .FRAME_DONE(fd0));

    seg_scan_ctrl #(.NDIG(6), .PRESCALE(32)) u1 (
        .CLK(CLK), .RESET(RESET), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .EN_MASK(EN_MASK), .BRIGHT(BRIGHT), .LZB(LZB),
        .SEG_C(seg1), .SEG_SEL(sel1), .FRAME_DONE(fd1));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
        end
    endtask

    // Next slot: first enabled digit walking forward from the current one, wrapping.
    function automatic int next_ptr(int d);
        int nxt = m_ptr[d];
        bit found = 0;
        for (int k = 1; k <= nd[d]; k++) begin
            int c = (m_ptr[d] + k) % nd[d];
            if (!found && EN_MASK[c]) begin
                nxt = c;
                found = 1;
            end
        end
        return nxt;
    endfunction

    function automatic logic [15:0] expect_out(int d);
        bit allz = 1;
        bit any = 0;
        bit dark, fd;
        int nxt = next_ptr(d);
        for (int j = 0; j < nd[d]; j++) begin
            if (EN_MASK[j]) any = 1;
            if (j >= m_ptr[d] && m_dig[d][j] != 0) allz = 0;
        end
        dark = m_pre[d] == 0 || !EN_MASK[m_ptr[d]] || m_pwm > BRIGHT ||
               (LZB && m_ptr[d] > 0 && allz);
        fd = m_pre[d] == ps[d] - 1 && any && nxt <= m_ptr[d];
        return {fd, dark ? 8'hFF : ~(8'h01 << m_ptr[d]), dark ? 7'h00 : lut[m_dig[d][m_ptr[d]]]};
    endfunction

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < 8; j++) m_dig[d][j] = 4'h0;
            m_ptr[d] = 0;
            m_pre[d] = 0;
        end
        m_pwm = 4'h0;
        q0.delete();
        q1.delete();
    endtask

    task automatic step();
        q0.push_back(expect_out(0));
        q1.push_back(expect_out(1));
        @(posedge CLK);
        for (int d = 0; d < 2; d++) begin
            if (WR_EN && int'(WR_ADDR) < nd[d]) m_dig[d][WR_ADDR] = WR_DATA;
            if (m_pre[d] == ps[d] - 1) begin
                m_ptr[d] = next_ptr(d);
                m_pre[d] = 0;
            end else m_pre[d]++;
        end
        m_pwm++;
        #1;
        chk("n8", {fd0, sel0, seg0}, q0.pop_front());
        chk("n6", {fd1, sel1, seg1}, q1.pop_front());
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] v);
        WR_EN = 1'b1;
        WR_ADDR = a;
        WR_DATA = v;
        step();
        WR_EN = 1'b0;
    endtask

    initial begin
        int cnt;
        reset_model();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_n8", {fd0, sel0, seg0}, {1'b0, 8'hFF, 7'h00});
        chk("rst_n6", {fd1, sel1, seg1}, {1'b0, 8'hFF, 7'h00});
        RESET = 1'b0;

        phase = "scan";
        run(8);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            cnt += int'(fd0);
        end
        chk("frame_per_32", 16'(cnt), 16'd1);

        phase = "write";
        wr(3'd2, 4'h7);
        wr(3'd5, 4'hA);
        wr(3'd7, 4'h3);
        run(70);

        phase = "mask";
        EN_MASK = 8'b0010_0101;
        run(40);
        cnt = 0;
        while (sel0 !== 8'hFB && cnt < 40) begin
            step();
            cnt++;
        end
        chk("found_fb", {8'h00, sel0}, {8'h00, 8'hFB});
        EN_MASK = 8'b0010_0001;
        step();
        chk("disabled_dark", {8'h00, sel0}, {8'h00, 8'hFF});
        run(20);
        EN_MASK = 8'h00;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            cnt += int'(fd0) + int'(fd1) + int'(sel0 != 8'hFF) + int'(sel1 != 8'hFF);
        end
        chk("idle_quiet", 16'(cnt), 16'd0);

        phase = "pwm";
        EN_MASK = 8'h01;
        BRIGHT = 4'h3;
        run(80);
        BRIGHT = 4'hF;
        run(40);

        phase = "lzb";
        EN_MASK = 8'hFF;
        wr(3'd0, 4'h5);
        wr(3'd1, 4'h0);
        wr(3'd2, 4'h3);
        for (int j = 3; j < 8; j++) wr(3'(j), 4'h0);
        LZB = 1'b1;
        run(70);
        wr(3'd0, 4'h0);
        wr(3'd2, 4'h0);
        run(70);

        phase = "async_rst";
        LZB = 1'b0;
        wr(3'd0, 4'h8);
        wr(3'd4, 4'h9);
        cnt = 0;
        while (sel0 === 8'hFF && cnt < 20) begin
            step();
            cnt++;
        end
        chk("lit_before", {8'h00, sel0 == 8'hFF ? 8'h01 : 8'h00}, 16'h0000);
        #2;
        RESET = 1'b1;
        #1;
        chk("mid_n8", {fd0, sel0, seg0}, {1'b0, 8'hFF, 7'h00});
        chk("mid_n6", {fd1, sel1, seg1}, {1'b0, 8'hFF, 7'h00});
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        reset_model();
        run(70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan scheduler for a multiplexed 8-digit common-anode 7-segment display bank. It holds a writable digit register file and time-shares the single SEG_C segment bus among enabled digits in round-robin slots. It also provides per-slot brightness PWM, ghost-suppression blanking and leading-zero blanking. It sits between counter/datapath blocks, which write BCD/hex nibbles, and the board display pins.

Parameters:
NDIG, 8, number of digits scanned (1..8); SEG_SEL bits above NDIG-1 are held 1.
PRESCALE, 10000, clock cycles per scan slot (>= 2).

Ports:
CLK  in  1  system clock; all state on posedge.
RESET  in  1  reset RESET, asynchronous, active-high.
WR_EN  in  1  write strobe for the digit register file.
WR_ADDR  in  3  digit index to write.
WR_DATA  in  4  nibble value, 0-F.
EN_MASK  in  8  per-digit scan enable; bit i enables digit i.
BRIGHT  in  4  brightness; lit duty is (BRIGHT+1)/16.
LZB  in  1  leading-zero blanking enable.
SEG_C  out  7  segments gfedcba, active-high, registered.
SEG_SEL  out  8  digit select, active-low, one-hot-low or all ones, registered.
FRAME_DONE  out  1  one-cycle pulse when the scan wraps.

Behaviour:
- Reset: digit regs = 0, scan pointer PTR = 0, prescaler = 0, pwm counter = 0, SEG_SEL = 8'hFF, SEG_C = 7'h00, FRAME_DONE = 0. Reset mid-scan aborts immediately, including the output pins.
- Writes: when WR_EN = 1 at a clock edge, digit[WR_ADDR] <= WR_DATA.
  - WR_ADDR >= NDIG is ignored.
  - A write to the displayed digit appears on SEG_C two edges later (reg update, then output reg).
- Prescaler: counts 0..PRESCALE-1 and wraps. TICK is asserted when count == PRESCALE-1.
- Pointer advance on TICK: PTR <= the lowest enabled index > PTR, else the lowest enabled index (wrap).
  - Only bits 0..NDIG-1 of EN_MASK count.
  - If no digit is enabled, PTR holds, and SEG_SEL/SEG_C stay at FF/00 permanently until a bit is set.
- FRAME_DONE is 1 for the cycle after a TICK whose new PTR <= old PTR. With one digit enabled it pulses every slot.
- PWM: a 4-bit free-running counter PWM increments every clock and is reset only by RESET. Digit is lit when PWM <= BRIGHT. BRIGHT = 15 gives always lit.
- Ghost blanking: during the first cycle of each slot (prescaler == 0), the output is dark.
- Dark means SEG_SEL = 8'hFF and SEG_C = 7'h00.
- Leading-zero blanking: if LZB = 1 and PTR > 0 and digit[j] == 0 for all j in PTR..NDIG-1, the current digit is dark. Digit 0 is never blanked.
- Disabled current digit: if EN_MASK[PTR] = 0 (mask changed mid-slot), the output is dark from the next cycle. The pointer moves at the next TICK per the rule above.
- Lit output: SEG_SEL = ~(1 << PTR). SEG_C = decode(digit[PTR]):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Latency: the combinational lit/dark decision is registered. Outputs reflect state with exactly 1 clock delay.
- Never more than one SEG_SEL bit low; no glitching between digits.

Test Plan:
1. Reset release with PRESCALE = 4, NDIG = 8, EN_MASK = FF, BRIGHT = F, LZB = 0, all digits 0 -> SEG_SEL steps FE, FD, ... 7F, FE every 4 clocks. Each slot's first output cycle is FF/00; SEG_C = 3F otherwise. FRAME_DONE pulses once per 32 clocks.
2. Write digit[2] = 7, digit[5] = A, then scan -> SEG_C = 07 while SEG_SEL = FB, and 77 while SEG_SEL = DF. A write with WR_ADDR beyond NDIG-1 (NDIG = 6) changes nothing.
3. EN_MASK = 8'b0010_0101 -> SEG_SEL sequence FE, FB, DF, FE only. Clearing bit 2 while SEG_SEL = FB -> dark next cycle, then DF at the next TICK. EN_MASK = 00 -> constant FF/00 and no FRAME_DONE.
4. BRIGHT = 3, PRESCALE = 32, single digit enabled -> lit exactly when PWM is 0-3, i.e. 4 of every 16 cycles, minus the ghost cycle. BRIGHT = F -> lit 31 of 32 cycles.
5. LZB = 1, digits {0:5, 1:0, 2:3, 3..7:0} -> digits 3-7 dark, digit 1 shows 3F, digit 2 shows 4F, digit 0 shows 6D. All digits 0 -> only digit 0 lit.
6. Assert RESET asynchronously mid-slot with digit data loaded -> SEG_SEL = FF and SEG_C = 00 before the next edge. After release, digits read 0 and the scan restarts at digit 0.
